param_bus_master: RTL and testbench
===================================

# param_bus_master

Register-bus initiator for the synth engine's parameter interface. It accepts single-access or burst commands on a valid/ready port and drives the engine-side `write`/`read`/`adr`/`synth_data_in`/bank-select signals with fixed setup, strobe and hold phases. For reads it samples `synth_data_out` and returns the bytes on a valid/ready response port. Sits between the SysEx/MIDI parameter decoder (or host bridge) and the synth engine, all in the `reg_clk` domain.

## Interface
- `READ_LAT`, 1 — cycles from the read-strobe cycle to the cycle in which `synth_data_out` is valid (range 1..4).
- `reg_clk`  in  1  register clock; the block's only clock.
- `reset_reg_N`  in  1  asynchronous, active-low reset.
- `cmd_valid` in 1; `cmd_ready` out 1  command handshake; transfer when both are high at a rising edge.
- `cmd_rd`  in  1  1 = read, 0 = write.
- `cmd_bank`  in  3  0 env, 1 osc, 2 m1, 3 m2, 4 com; 5..7 invalid.
- `cmd_adr`  in  7  start address.
- `cmd_data`  in  8  write data; ignored for reads.
- `cmd_len`  in  8  read burst length minus one; ignored for writes.
- `rsp_valid` out 1; `rsp_ready` in 1  response handshake.
- `rsp_data`  out  8  read byte.
- `rsp_last`  out  1  final beat of the command.
- `rsp_err`  out  1  invalid bank.
- `write`, `read`  out  1  one-cycle engine strobes.
- `adr`  out  7  engine address.
- `synth_data_in`  out  8  engine write data.
- `synth_data_out`  in  8  engine read data.
- `env_sel`, `osc_sel`, `m1_sel`, `m2_sel`, `com_sel`  out  1  bank selects, one-hot or all zero.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, SETUP, STROBE, WAIT, CAPTURE, HOLD, RESP.
- **IDLE**
  - `cmd_ready` = 1 only in IDLE.
  - On accept, latch bank, address, data, rd and length into registers.
  - Valid bank → SETUP.
  - Invalid bank → RESP with `rsp_err`=1, `rsp_data`=0, `rsp_last`=1. No select or strobe is ever driven.
- **SETUP** — the bank select, `adr` and `synth_data_in` (writes) are driven. → STROBE.
- **STROBE** — `write` or `read` = 1 for exactly this cycle; select and `adr` held.
  - Write → HOLD.
  - Read → WAIT (READ_LAT > 1) or CAPTURE (READ_LAT = 1).
- **WAIT** — READ_LAT−1 cycles, select and `adr` held. → CAPTURE.
- **CAPTURE** — select and `adr` held; `synth_data_out` is registered at the end of this cycle. → RESP.
- **HOLD** — select, `adr` and data held one cycle after the write strobe. Selects then drop. → IDLE.
- **RESP**
  - `rsp_valid` = 1 and `rsp_data` stable until `rsp_ready`. Selects are low.
  - `rsp_last` = 1 when the remaining count is 0.
  - On handshake: if more beats remain, `adr` ← `adr`+1 mod 128 (127 wraps to 0), count−1, → SETUP. Otherwise → IDLE.
- Writes produce no response beat unless the bank is invalid.
- The remaining count is 8 bits, so `cmd_len`=255 gives 256 beats, wrapping the address twice.
- Outputs during IDLE: all selects and strobes 0. `adr` and `synth_data_in` keep their last values.

## Timing
- Reset (asynchronous, immediate): FSM=IDLE, `cmd_ready`=1, `rsp_valid`/`rsp_last`/`rsp_err`=0, `rsp_data`=0, `write`/`read`=0, all selects 0, `adr`=0, `synth_data_in`=0, `busy`=0.
- Reset mid-burst aborts without a final beat; no partial strobe ever lasts past the reset assertion.
- Write: accept edge E0. SETUP in cycle 1, STROBE in cycle 2, HOLD in cycle 3, `cmd_ready` high again in cycle 4. Throughput is one write per 4 cycles.
- Read beat with READ_LAT=1: SETUP, STROBE, CAPTURE, then RESP, so `rsp_valid` is first high 4 cycles after accept.
- Each additional READ_LAT cycle adds one cycle.
- Backpressure: `rsp_ready` low stalls in RESP indefinitely. No engine access occurs during a stall.
- `cmd_valid` during busy is ignored (not accepted); the command stays pending upstream.
- A command presented in the same cycle the FSM returns to IDLE is accepted on the next edge.

## Structure
- Shared package `param_bus_pkg`:
  - bank enum (ENV, OSC, M1, M2, COM);
  - `bank_to_sel` one-hot function, returning 0 for invalid codes;
  - FSM state enum.
- Single module; no sub-module needed. Strobe and select outputs are registered directly (no combinational decode to the pins).

## Test plan
- Write bank OSC, adr 0x16, data 0x5A → `osc_sel` high cycles 1–3, `write` high cycle 2 only, `adr`=0x16 and `synth_data_in`=0x5A cycles 1–3, no `rsp_valid`.
- Read bank ENV, adr 0x10, len 0, with engine model returning 0x33 at that address (READ_LAT=1) → single beat `rsp_data`=0x33, `rsp_last`=1, `rsp_valid` first high 4 cycles after accept.
- Read burst COM, adr 0x7E, len 2 → `read` strobes at `adr` 0x7E, 0x7F, 0x00. Three beats with `rsp_last` only on the third.
- Burst with `rsp_ready` held low 10 cycles on beat 2 → `rsp_data` stable throughout, no `read` strobe during the stall, then resumes.
- Command with bank 6 (read and write) → one beat `rsp_err`=1, `rsp_data`=0, no select or strobe ever high.
- Assert `reset_reg_N` low during WAIT (READ_LAT=3) → all outputs at reset values in the same cycle, `cmd_ready`=1 after release, next command executes normally.

Source files
------------

// File: rtl/param_bus_pkg.sv
// Shared types for the synth-engine parameter bus: bank codes, bank-select decode and the
// initiator FSM state encoding.
package param_bus_pkg;

  typedef enum logic [2:0] {
    BankEnv = 3'd0,
    BankOsc = 3'd1,
    BankM1  = 3'd2,
    BankM2  = 3'd3,
    BankCom = 3'd4
  } bank_e;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StStrobe,
    StWait,
    StCapture,
    StHold,
    StResp
  } state_e;

  // Bit order of the result: {com, m2, m1, osc, env}; codes 5..7 decode to no select.
  function automatic logic [4:0] bank_to_sel(logic [2:0] bank);
    logic [4:0] sel;
    sel = '0;
    case (bank_e'(bank))
      BankEnv: sel = 5'b00001;
      BankOsc: sel = 5'b00010;
      BankM1:  sel = 5'b00100;
      BankM2:  sel = 5'b01000;
      BankCom: sel = 5'b10000;
      default: sel = 5'b00000;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/param_bus_master.sv
// Parameter-bus initiator: sequences setup/strobe/hold accesses into the synth engine banks
// and returns read bytes (one per burst beat) on a valid/ready response port.
module param_bus_master
  import param_bus_pkg::*;
#(
  parameter int unsigned READ_LAT = 1
) (
  input  logic       reg_clk,
  input  logic       reset_reg_N,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rd,
  input  logic [2:0] cmd_bank,
  input  logic [6:0] cmd_adr,
  input  logic [7:0] cmd_data,
  input  logic [7:0] cmd_len,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_last,
  output logic       rsp_err,
  output logic       write,
  output logic       read,
  output logic [6:0] adr,
  output logic [7:0] synth_data_in,
  input  logic [7:0] synth_data_out,
  output logic       env_sel,
  output logic       osc_sel,
  output logic       m1_sel,
  output logic       m2_sel,
  output logic       com_sel,
  output logic       busy
);

  // WAIT is entered only when READ_LAT > 1 and lasts READ_LAT-1 cycles.
  localparam logic [1:0] WaitInit = (READ_LAT > 1) ? 2'(READ_LAT - 2) : 2'd0;

  state_e      state_q, state_d;
  logic [2:0]  bank_q, bank_d;
  logic        rd_q, rd_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  wait_q, wait_d;
  logic [6:0]  adr_q, adr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rsp_data_q, rsp_data_d;

  logic [4:0]  sel_q, sel_d;
  logic        write_q, write_d;
  logic        read_q, read_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_last_q, rsp_last_d;
  logic        rsp_err_q, rsp_err_d;
  logic        busy_q, busy_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        in_access;

  always_comb begin
    state_d    = state_q;
    bank_d     = bank_q;
    rd_d       = rd_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    wait_d     = wait_q;
    adr_d      = adr_q;
    wdata_d    = wdata_q;
    rsp_data_d = rsp_data_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          bank_d = cmd_bank;
          rd_d   = cmd_rd;
          adr_d  = cmd_adr;
          cnt_d  = cmd_rd ? cmd_len : 8'd0;
          if (!cmd_rd) begin
            wdata_d = cmd_data;
          end
          if (bank_to_sel(cmd_bank) == 5'b00000) begin
            // Invalid bank: answer with a single error beat, never touch the engine.
            err_d      = 1'b1;
            cnt_d      = 8'd0;
            rsp_data_d = 8'h00;
            state_d    = StResp;
          end else begin
            err_d   = 1'b0;
            state_d = StSetup;
          end
        end
      end
      StSetup: state_d = StStrobe;
      StStrobe: begin
        if (!rd_q) begin
          state_d = StHold;
        end else if (READ_LAT > 1) begin
          wait_d  = WaitInit;
          state_d = StWait;
        end else begin
          state_d = StCapture;
        end
      end
      StWait: begin
        if (wait_q == 2'd0) begin
          state_d = StCapture;
        end else begin
          wait_d = wait_q - 2'd1;
        end
      end
      StCapture: begin
        rsp_data_d = synth_data_out;
        state_d    = StResp;
      end
      StHold: state_d = StIdle;
      StResp: begin
        if (rsp_ready) begin
          if (cnt_q != 8'd0) begin
            adr_d   = adr_q + 7'd1;
            cnt_d   = cnt_q - 8'd1;
            state_d = StSetup;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Pin values are decoded from the next state so every output comes straight from a flop.
    in_access   = (state_d == StSetup) || (state_d == StStrobe) || (state_d == StWait) ||
                  (state_d == StCapture) || (state_d == StHold);
    sel_d       = in_access ? bank_to_sel(bank_d) : 5'b00000;
    write_d     = (state_d == StStrobe) && !rd_d;
    read_d      = (state_d == StStrobe) && rd_d;
    rsp_valid_d = (state_d == StResp);
    rsp_last_d  = (state_d == StResp) && (cnt_d == 8'd0);
    rsp_err_d   = (state_d == StResp) && err_d;
    busy_d      = (state_d != StIdle);
    cmd_ready_d = (state_d == StIdle);
  end

  always_ff @(posedge reg_clk or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      state_q     <= StIdle;
      bank_q      <= 3'd0;
      rd_q        <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= 8'd0;
      wait_q      <= 2'd0;
      adr_q       <= 7'd0;
      wdata_q     <= 8'd0;
      rsp_data_q  <= 8'd0;
      sel_q       <= 5'b00000;
      write_q     <= 1'b0;
      read_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      bank_q      <= bank_d;
      rd_q        <= rd_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      wait_q      <= wait_d;
      adr_q       <= adr_d;
      wdata_q     <= wdata_d;
      rsp_data_q  <= rsp_data_d;
      sel_q       <= sel_d;
      write_q     <= write_d;
      read_q      <= read_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_last_q  <= rsp_last_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_last      = rsp_last_q;
  assign rsp_err       = rsp_err_q;
  assign write         = write_q;
  assign read          = read_q;
  assign adr           = adr_q;
  assign synth_data_in = wdata_q;
  assign env_sel       = sel_q[0];
  assign osc_sel       = sel_q[1];
  assign m1_sel        = sel_q[2];
  assign m2_sel        = sel_q[3];
  assign com_sel       = sel_q[4];
  assign busy          = busy_q;

endmodule

// File: tb/tb_param_bus_master.sv
// Bench for param_bus_master: instance 0 uses READ_LAT=1, instance 1 uses READ_LAT=3; read
// responses are checked against a scoreboard of hand-computed bytes.
module tb_param_bus_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst_n, cmd_valid, cmd_ready, cmd_rd, rsp_valid, rsp_ready;
  logic [1:0]       rsp_last, rsp_err, write_s, read_s, busy;
  logic [1:0][2:0]  cmd_bank;
  logic [1:0][6:0]  cmd_adr, adr;
  logic [1:0][7:0]  cmd_data, cmd_len, rsp_data, sdi, sdo;
  logic [1:0][4:0]  sels;
  logic [1:0][2:0][7:0] pipe;

  int n_checks = 0;
  int n_fail   = 0;
  int beats [2];
  logic [9:0] exp0 [$];
  logic [9:0] exp1 [$];

  for (genvar i = 0; i < 2; i++) begin : g_dut
    param_bus_master #(.READ_LAT(i == 0 ? 1 : 3)) u_dut (
      .reg_clk        (clk),
      .reset_reg_N    (rst_n[i]),
      .cmd_valid      (cmd_valid[i]),
      .cmd_ready      (cmd_ready[i]),
      .cmd_rd         (cmd_rd[i]),
      .cmd_bank       (cmd_bank[i]),
      .cmd_adr        (cmd_adr[i]),
      .cmd_data       (cmd_data[i]),
      .cmd_len        (cmd_len[i]),
      .rsp_valid      (rsp_valid[i]),
      .rsp_ready      (rsp_ready[i]),
      .rsp_data       (rsp_data[i]),
      .rsp_last       (rsp_last[i]),
      .rsp_err        (rsp_err[i]),
      .write          (write_s[i]),
      .read           (read_s[i]),
      .adr            (adr[i]),
      .synth_data_in  (sdi[i]),
      .synth_data_out (sdo[i]),
      .env_sel        (sels[i][0]),
      .osc_sel        (sels[i][1]),
      .m1_sel         (sels[i][2]),
      .m2_sel         (sels[i][3]),
      .com_sel        (sels[i][4]),
      .busy           (busy[i])
    );
  end

  // Engine contents: adr + 0x23 + 0x10 * bank code.
  function automatic logic [7:0] mem_val(logic [4:0] s, logic [6:0] a);
    logic [7:0] b;
    case (s)
      5'b00001: b = 8'h00;
      5'b00010: b = 8'h10;
      5'b00100: b = 8'h20;
      5'b01000: b = 8'h30;
      5'b10000: b = 8'h40;
      default:  b = 8'hC0;
    endcase
    return {1'b0, a} + 8'h23 + b;
  endfunction

  // Engine read pipeline; data is only valid READ_LAT cycles after the strobe, junk otherwise.
  initial pipe = '1;
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      pipe[i][0] <= read_s[i] ? mem_val(sels[i], adr[i]) : 8'hEE;
      pipe[i][1] <= pipe[i][0];
      pipe[i][2] <= pipe[i][1];
    end
  end
  assign sdo[0] = pipe[0][0];
  assign sdo[1] = pipe[1][2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] outs(int w);
    return {29'd0, cmd_ready[w], busy[w], rsp_valid[w], rsp_last[w], rsp_err[w], rsp_data[w],
            write_s[w], read_s[w], sels[w], adr[w], sdi[w]};
  endfunction

  localparam logic [63:0] ResetOuts = {29'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00,
                                       1'b0, 1'b0, 5'b00000, 7'h00, 8'h00};

  // Response monitor: pops the scoreboard on every handshake.
  always @(negedge clk) begin
    logic [9:0] got, e;
    for (int i = 0; i < 2; i++) begin
      if (rst_n[i] && rsp_valid[i] && rsp_ready[i]) begin
        got = {rsp_err[i], rsp_last[i], rsp_data[i]};
        if ((i == 0 && exp0.size() == 0) || (i == 1 && exp1.size() == 0)) begin
          n_checks++;
          n_fail++;
          $display("FAIL rsp_unexpected dut%0d: got %h expected no beat", i, got);
        end else begin
          if (i == 0) e = exp0.pop_front();
          else        e = exp1.pop_front();
          check($sformatf("rsp_beat dut%0d", i), 64'(got), 64'(e));
        end
        beats[i]++;
      end
    end
  end

  // Returns at the negedge of the first cycle after the accept edge.
  task automatic send(input int w, input logic rd, input logic [2:0] bank, input logic [6:0] a,
                      input logic [7:0] d, input logic [7:0] len);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready[w] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout dut%0d: cmd_ready 0 expected 1", w);
    end
    cmd_valid[w] = 1'b1;
    cmd_rd[w]    = rd;
    cmd_bank[w]  = bank;
    cmd_adr[w]   = a;
    cmd_data[w]  = d;
    cmd_len[w]   = len;
    @(posedge clk);
    #1;
    cmd_valid[w] = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_idle(input int w, output logic act);
    int n = 0;
    act = 1'b0;
    while (n < 300) begin
      act |= (|sels[w]) | write_s[w] | read_s[w];
      if (!busy[w] && ((w == 0) ? exp0.size() == 0 : exp1.size() == 0)) break;
      @(negedge clk);
      n++;
    end
    check($sformatf("idle_reached dut%0d", w), 64'(n < 300), 64'd1);
  endtask

  initial begin
    logic act;
    logic [7:0] held;
    int n;
    beats[0] = 0;
    beats[1] = 0;
    rst_n     = 2'b00;
    cmd_valid = 2'b00;
    cmd_rd    = 2'b00;
    cmd_bank  = '0;
    cmd_adr   = '0;
    cmd_data  = '0;
    cmd_len   = '0;
    rsp_ready = 2'b11;
    repeat (2) @(negedge clk);
    check("reset_outs dut0", outs(0), ResetOuts);
    check("reset_outs dut1", outs(1), ResetOuts);
    rst_n = 2'b11;

    // Write OSC 0x16 <- 0x5A: select cycles 1-3, strobe cycle 2 only, ready again cycle 4.
    send(0, 1'b0, 3'd1, 7'h16, 8'h5A, 8'd0);
    check("wr_cycle1", {sels[0], write_s[0], read_s[0], adr[0], sdi[0]},
          {5'b00010, 1'b0, 1'b0, 7'h16, 8'h5A});
    @(negedge clk);
    check("wr_cycle2", {sels[0], write_s[0], read_s[0], adr[0], sdi[0]},
          {5'b00010, 1'b1, 1'b0, 7'h16, 8'h5A});
    @(negedge clk);
    check("wr_cycle3", {sels[0], write_s[0], read_s[0], adr[0], sdi[0]},
          {5'b00010, 1'b0, 1'b0, 7'h16, 8'h5A});
    @(negedge clk);
    check("wr_cycle4", {sels[0], write_s[0], cmd_ready[0], busy[0]}, {5'b00000, 1'b0, 1'b1, 1'b0});

    // Single read ENV 0x10 -> 0x33; rsp_valid first high 4 cycles after accept.
    exp0.push_back({1'b0, 1'b1, 8'h33});
    send(0, 1'b1, 3'd0, 7'h10, 8'h00, 8'd0);
    for (int k = 1; k < 4; k++) begin
      check($sformatf("rd_latency_c%0d", k), 64'(rsp_valid[0]), 64'd0);
      @(negedge clk);
    end
    check("rd_latency_c4", 64'(rsp_valid[0]), 64'd1);
    wait_idle(0, act);

    // Burst COM from 0x7E, three beats wrapping to 0x00.
    exp0.push_back({1'b0, 1'b0, 8'hE1});
    exp0.push_back({1'b0, 1'b0, 8'hE2});
    exp0.push_back({1'b0, 1'b1, 8'h63});
    send(0, 1'b1, 3'd4, 7'h7E, 8'h00, 8'd2);
    wait_idle(0, act);

    // Burst ENV from 0x20 with beat 2 back-pressured for 10 cycles.
    exp0.push_back({1'b0, 1'b0, 8'h43});
    exp0.push_back({1'b0, 1'b0, 8'h44});
    exp0.push_back({1'b0, 1'b1, 8'h45});
    n = beats[0];
    send(0, 1'b1, 3'd0, 7'h20, 8'h00, 8'd2);
    for (int k = 0; k < 100 && beats[0] == n; k++) @(negedge clk);
    @(posedge clk);
    #1;
    rsp_ready[0] = 1'b0;
    for (int k = 0; k < 20 && !rsp_valid[0]; k++) @(negedge clk);
    held = rsp_data[0];
    check("stall_beat2_data", 64'(held), 64'h44);
    for (int k = 0; k < 10; k++) begin
      check("stall_hold", {rsp_valid[0], read_s[0], sels[0], rsp_data[0]},
            {1'b1, 1'b0, 5'b00000, held});
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    rsp_ready[0] = 1'b1;
    wait_idle(0, act);

    // Invalid bank, read (len ignored) and write: one error beat, no engine access.
    exp0.push_back({1'b1, 1'b1, 8'h00});
    send(0, 1'b1, 3'd6, 7'h11, 8'h00, 8'd3);
    wait_idle(0, act);
    check("err_rd_no_access", 64'(act), 64'd0);
    exp0.push_back({1'b1, 1'b1, 8'h00});
    send(0, 1'b0, 3'd6, 7'h12, 8'hAA, 8'd0);
    wait_idle(0, act);
    check("err_wr_no_access", 64'(act), 64'd0);

    // Reset during WAIT on the READ_LAT=3 instance, then a clean read.
    send(1, 1'b1, 3'd0, 7'h05, 8'h00, 8'd0);
    repeat (2) @(negedge clk);
    check("in_wait", {busy[1], read_s[1], sels[1], adr[1]}, {1'b1, 1'b0, 5'b00001, 7'h05});
    #1;
    rst_n[1] = 1'b0;
    #1;
    check("reset_midburst", outs(1), ResetOuts);
    @(negedge clk);
    rst_n[1] = 1'b1;
    @(negedge clk);
    check("ready_after_reset", {cmd_ready[1], busy[1]}, {1'b1, 1'b0});
    exp1.push_back({1'b0, 1'b1, 8'h28});
    send(1, 1'b1, 3'd0, 7'h05, 8'h00, 8'd0);
    for (int k = 1; k < 6; k++) begin
      check($sformatf("lat3_c%0d", k), 64'(rsp_valid[1]), 64'd0);
      @(negedge clk);
    end
    check("lat3_c6", 64'(rsp_valid[1]), 64'd1);
    wait_idle(1, act);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
